// File: rtl/peripheral_dbg_pu_riscv_datafifo_if.sv
// Debug data FIFO bus: push/pop strobes, data, status and sticky error flags.
// Clock and reset stay as plain ports on the FIFO itself.
interface peripheral_dbg_pu_riscv_datafifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             FLUSH;
  logic             PUSH;
  logic [WIDTH-1:0] DATA_IN;
  logic             POP;
  logic [WIDTH-1:0] DATA_OUT;
  logic [CW-1:0]    BYTES_AVAIL;
  logic [CW-1:0]    BYTES_FREE;
  logic             EMPTY;
  logic             FULL;
  logic             ALMOST_FULL;
  logic             ERR_CLR;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  // FIFO side
  modport slave (
    input  FLUSH, PUSH, DATA_IN, POP, ERR_CLR,
    output DATA_OUT, BYTES_AVAIL, BYTES_FREE, EMPTY, FULL, ALMOST_FULL,
           OVERFLOW, UNDERFLOW
  );

  // Producer/consumer side
  modport master (
    output FLUSH, PUSH, DATA_IN, POP, ERR_CLR,
    input  DATA_OUT, BYTES_AVAIL, BYTES_FREE, EMPTY, FULL, ALMOST_FULL,
           OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/peripheral_dbg_pu_riscv_datafifo.sv
// Parametrised first-word-fall-through FIFO for the debug data path.
// Circular buffer with independent read/write pointers, any DEPTH >= 2.
// Optional sticky overflow/underflow flags: define PERIPHERAL_DBG_FIFO_ERR_EN.
module peripheral_dbg_pu_riscv_datafifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AFULL = 6
) (
  input  logic CLK,
  input  logic RSTN,
  peripheral_dbg_pu_riscv_datafifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_push_ok;
  logic w_pop_ok;

  // Status is derived only from the registered count.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A pop at FULL frees the slot the simultaneous push lands in; flush discards both.
  assign w_pop_ok  = bus.POP & ~w_empty & ~bus.FLUSH;
  assign w_push_ok = bus.PUSH & (~w_full | bus.POP) & ~bus.FLUSH;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage write; contents intentionally not reset.
  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= bus.DATA_IN;
  end

  // Pointer and occupancy tracking; flush clears everything but the error flags.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.DATA_OUT    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.BYTES_AVAIL = r_count;
  assign bus.BYTES_FREE  = CW'(DEPTH) - r_count;
  assign bus.EMPTY       = w_empty;
  assign bus.FULL        = w_full;
  assign bus.ALMOST_FULL = (r_count >= CW'(AFULL));

`ifdef PERIPHERAL_DBG_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_ovf_set = bus.PUSH & w_full & ~bus.POP & ~bus.FLUSH;
  assign w_udf_set = bus.POP & w_empty & ~bus.FLUSH;

  // Sticky error flags; a new error in the clear cycle takes precedence.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (bus.ERR_CLR) r_ovf <= 1'b0;
      if (w_udf_set)        r_udf <= 1'b1;
      else if (bus.ERR_CLR) r_udf <= 1'b0;
    end
  end

  assign bus.OVERFLOW  = r_ovf;
  assign bus.UNDERFLOW = r_udf;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.ERR_CLR;
  assign bus.OVERFLOW     = 1'b0;
  assign bus.UNDERFLOW    = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_datafifo.sv
// Scoreboard bench: an 8-deep and a 5-deep FIFO sharing clock and reset.
module tb_peripheral_dbg_pu_riscv_datafifo;
  logic CLK;
  logic RSTN;

  peripheral_dbg_pu_riscv_datafifo_if #(.WIDTH(8), .DEPTH(8)) b8 ();
  peripheral_dbg_pu_riscv_datafifo_if #(.WIDTH(8), .DEPTH(5)) b5 ();

  peripheral_dbg_pu_riscv_datafifo #(.WIDTH(8), .DEPTH(8), .AFULL(6)) u_d8 (
    .CLK(CLK), .RSTN(RSTN), .bus(b8.slave));
  peripheral_dbg_pu_riscv_datafifo #(.WIDTH(8), .DEPTH(5), .AFULL(4)) u_d5 (
    .CLK(CLK), .RSTN(RSTN), .bus(b5.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] q8[$];
  logic [7:0] q5[$];
  bit         m_ovf[2];
  bit         m_udf[2];
  int         max5;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare every status output of one instance against the queue model.
  task automatic chk_status(input bit s);
    int sz, dep, af;
    logic [7:0] dout_exp;
    sz  = s ? q5.size() : q8.size();
    dep = s ? 5 : 8;
    af  = s ? 4 : 6;
    dout_exp = (sz == 0) ? 8'h00 : (s ? q5[0] : q8[0]);
    if (s) begin
      chk("d5_avail", 32'(b5.BYTES_AVAIL), 32'(sz));
      chk("d5_free",  32'(b5.BYTES_FREE),  32'(dep - sz));
      chk("d5_empty", 32'(b5.EMPTY),       32'(sz == 0));
      chk("d5_full",  32'(b5.FULL),        32'(sz == dep));
      chk("d5_afull", 32'(b5.ALMOST_FULL), 32'(sz >= af));
      chk("d5_dout",  32'(b5.DATA_OUT),    32'(dout_exp));
      chk("d5_ovf",   32'(b5.OVERFLOW),    32'(m_ovf[1]));
      chk("d5_udf",   32'(b5.UNDERFLOW),   32'(m_udf[1]));
    end else begin
      chk("d8_avail", 32'(b8.BYTES_AVAIL), 32'(sz));
      chk("d8_free",  32'(b8.BYTES_FREE),  32'(dep - sz));
      chk("d8_empty", 32'(b8.EMPTY),       32'(sz == 0));
      chk("d8_full",  32'(b8.FULL),        32'(sz == dep));
      chk("d8_afull", 32'(b8.ALMOST_FULL), 32'(sz >= af));
      chk("d8_dout",  32'(b8.DATA_OUT),    32'(dout_exp));
      chk("d8_ovf",   32'(b8.OVERFLOW),    32'(m_ovf[0]));
      chk("d8_udf",   32'(b8.UNDERFLOW),   32'(m_udf[0]));
    end
  endtask

  // One clock of stimulus on instance s; popped words are checked before the edge.
  task automatic cyc(input bit s, input bit push, input bit pop, input bit flush,
                     input bit eclr, input logic [7:0] din);
    int  sz, dep;
    bit  empty, full, pok, wok;
    logic [7:0] exp;
    sz    = s ? q5.size() : q8.size();
    dep   = s ? 5 : 8;
    empty = (sz == 0);
    full  = (sz == dep);
    pok   = pop && !empty && !flush;
    wok   = push && (!full || pop) && !flush;
`ifdef PERIPHERAL_DBG_FIFO_ERR_EN
    if (push && full && !pop && !flush) m_ovf[s] = 1'b1;
    else if (eclr)                      m_ovf[s] = 1'b0;
    if (pop && empty && !flush)         m_udf[s] = 1'b1;
    else if (eclr)                      m_udf[s] = 1'b0;
`endif
    if (pok) begin
      exp = s ? q5.pop_front() : q8.pop_front();
      chk(s ? "d5_pop_data" : "d8_pop_data", 32'(s ? b5.DATA_OUT : b8.DATA_OUT), 32'(exp));
    end
    if (s) begin
      b5.PUSH = push; b5.POP = pop; b5.FLUSH = flush; b5.ERR_CLR = eclr; b5.DATA_IN = din;
    end else begin
      b8.PUSH = push; b8.POP = pop; b8.FLUSH = flush; b8.ERR_CLR = eclr; b8.DATA_IN = din;
    end
    @(posedge CLK); #1;
    b5.PUSH = 0; b5.POP = 0; b5.FLUSH = 0; b5.ERR_CLR = 0;
    b8.PUSH = 0; b8.POP = 0; b8.FLUSH = 0; b8.ERR_CLR = 0;
    if (flush) begin
      if (s) q5.delete(); else q8.delete();
    end else if (wok) begin
      if (s) q5.push_back(din); else q8.push_back(din);
    end
    if (s && q5.size() > max5) max5 = q5.size();
    chk_status(s);
  endtask

  initial begin
    RSTN = 1'b0;
    b8.PUSH = 0; b8.POP = 0; b8.FLUSH = 0; b8.ERR_CLR = 0; b8.DATA_IN = '0;
    b5.PUSH = 0; b5.POP = 0; b5.FLUSH = 0; b5.ERR_CLR = 0; b5.DATA_IN = '0;
    max5 = 0;
    #12;
    chk_status(0);
    chk_status(1);
    @(negedge CLK); RSTN = 1'b1;
    @(posedge CLK); #1;

    // Fill and drain in order
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 0, 0, 8'(i));
    for (int i = 0; i < 8; i++)  cyc(0, 0, 1, 0, 0, 8'h00);

    // Simultaneous push+pop at FULL, then at EMPTY
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 0, 0, 8'(8'h10 + i));
    cyc(0, 1, 1, 0, 0, 8'hAA);
    for (int i = 0; i < 8; i++)  cyc(0, 0, 1, 0, 0, 8'h00);
    cyc(0, 1, 1, 0, 0, 8'h55);
    cyc(0, 0, 1, 0, 0, 8'h00);

    // Flush discards a concurrent push; later push reads back
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 8'(8'h30 + i));
    cyc(0, 1, 0, 1, 0, 8'h77);
    cyc(0, 1, 0, 0, 0, 8'h12);
    cyc(0, 0, 1, 0, 0, 8'h00);

    // Error flags: clear, overflow at FULL, underflow at EMPTY, clear again
    cyc(0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 8'(8'h40 + i));
    cyc(0, 1, 0, 0, 0, 8'hEE);
`ifdef PERIPHERAL_DBG_FIFO_ERR_EN
    chk("ovf_set", 32'(b8.OVERFLOW), 32'd1);
`else
    chk("ovf_off", 32'(b8.OVERFLOW), 32'd0);
`endif
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
`ifdef PERIPHERAL_DBG_FIFO_ERR_EN
    chk("udf_set", 32'(b8.UNDERFLOW), 32'd1);
`else
    chk("udf_off", 32'(b8.UNDERFLOW), 32'd0);
`endif
    cyc(0, 0, 0, 0, 1, 8'h00);
    chk("err_clr", 32'({b8.OVERFLOW, b8.UNDERFLOW}), 32'd0);

    // Wrap on the 5-deep instance
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 8'(r * 3 + i + 1));
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 8'h00);
    end
    chk("d5_wrap_max", 32'(max5), 32'd3);

    // Asynchronous reset mid-traffic, no clock edge in between
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 8'(8'h60 + i));
    cyc(1, 1, 0, 0, 0, 8'h99);
    RSTN = 1'b0;
    #1;
    q8.delete(); q5.delete();
    m_ovf[0] = 0; m_ovf[1] = 0; m_udf[0] = 0; m_udf[1] = 0;
    chk("rst_empty", 32'(b8.EMPTY), 32'd1);
    chk("rst_free",  32'(b8.BYTES_FREE), 32'd8);
    chk_status(0);
    chk_status(1);
    @(negedge CLK); RSTN = 1'b1;
    @(posedge CLK); #1;
    cyc(0, 1, 0, 0, 0, 8'h5A);
    cyc(0, 0, 1, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Hard time bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "timeout");
  end
endmodule
